hi_priority_arbiter: RTL and testbench
======================================

Name: hi_priority_arbiter

Overview:
- Sequential arbiter for a 4-bit highest-index priority encoder datapath.
- Samples 4 request lines and grants one shared resource to the highest-index eligible requester.
- Holds the grant until the winner releases it or a hold-time limit expires.
- Masks a pre-empted winner for one arbitration so lower requesters are not starved.
- Sits between requester blocks and the shared resource; the encoder is instantiated inside.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles per grant (legal range 2..255).
- CNT_W, 8, width of the hold counter (must hold MAX_HOLD-1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ  input  4  request lines; bit i = requester i; higher index = higher priority.
- GNT  output  4  one-hot grant, registered; 0000 when nobody is granted.
- IDX  output  2  index of current grantee, registered; valid only when VALID=1.
- VALID  output  1  high whenever GNT != 0000.
- PREEMPT  output  1  one-cycle pulse, the cycle after a forced release.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = IDLE; GNT=0000, IDX=00, VALID=0, PREEMPT=0.
  - hold_cnt=0, mask=0000.
  - Takes effect immediately, including mid-grant.
  - On release of reset, the first arbitration occurs at the first rising edge with RST_N high.
- Encoder (combinational): masked = REQ & ~mask; enc_idx = highest set bit of masked; enc_z = (masked == 0000).
- IDLE:
  - If enc_z=0: at the next edge go to GRANT; GNT = onehot(enc_idx), IDX = enc_idx, VALID=1, hold_cnt=0, mask=0000.
  - If enc_z=1: stay in IDLE; mask=0000. This clears a stale mask, so a lone masked requester wins one cycle later.
- GRANT (hold_cnt increments by 1 each cycle in GRANT):
  - Voluntary release: if REQ[IDX]=0, next edge goes to IDLE with GNT=0000, VALID=0, mask unchanged (0000).
  - Forced release: if REQ[IDX]=1 and hold_cnt == MAX_HOLD-1, next edge goes to IDLE with GNT=0000, VALID=0, mask=onehot(IDX), PREEMPT=1 for exactly that one cycle.
  - Otherwise stay in GRANT; GNT and IDX stay stable.
  - Changes on other REQ bits during GRANT are ignored; there is no mid-grant pre-emption by higher priority.
- Latency:
  - REQ asserted before edge t (in IDLE) gives GNT asserted after edge t, i.e. 1 cycle.
  - At least one IDLE cycle with GNT=0000 separates any two grants (handover gap).
  - A grant lasts at most MAX_HOLD cycles.
- Simultaneous events:
  - Release and hold limit in the same cycle count as voluntary (PREEMPT=0, no mask).
  - Reset asserted in the same cycle as any event wins.
- Invariants:
  - GNT is always 0000 or one-hot.
  - VALID == |GNT; IDX == encoder of GNT when VALID=1.
  - PREEMPT is never high two cycles in a row.
- Width rule: hold_cnt saturates nowhere; it is compared for equality and reset to 0 on entering GRANT.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE=1'b0, GRANT=1'b1).
  - NUM_REQ=4.
  - Default MAX_HOLD.
- Sub-module hi_index_enc: combinational, 4-bit input, outputs 2-bit index and zero flag. It has the same function as the existing highest-index encoder, is reused as-is, and is instantiated once on masked.
- Top contains the FSM, hold counter, mask register and output registers.

Test Plan:
- Reset: drive REQ=1111, assert RST_N low mid-GRANT -> GNT=0000, VALID=0, PREEMPT=0 immediately (asynchronously); after release, GNT=1000 one edge later.
- Priority: REQ=0101 from IDLE -> next edge GNT=0100, IDX=10, VALID=1; GNT stays 0100 while REQ[2]=1 (< MAX_HOLD cycles).
- Handover: holder drops REQ[2] with REQ=0001 -> one cycle GNT=0000, then GNT=0001, IDX=00.
- Pre-emption (MAX_HOLD=8): REQ=1001 held constant -> GNT=1000 for exactly 8 cycles, then GNT=0000 with PREEMPT=1, then GNT=0001. After REQ[0] drops: one gap cycle, then GNT=1000 again.
- Lone masked requester: REQ=1000 only, held through a forced release -> GNT=0000 for 2 cycles (gap, then mask-clear), then GNT=1000.
- Idle/no requests: REQ=0000 for 10 cycles -> GNT=0000, VALID=0, PREEMPT=0 throughout. Then sweep all 16 REQ values from IDLE -> granted index equals the highest set bit each time.

Source files
------------

// File: rtl/hi_priority_arbiter_pkg.sv
// Shared types and constants for the highest-index priority arbiter.
// Request width, state encoding and default hold limits.
package hi_priority_arbiter_pkg;

   localparam int NUM_REQ      = 4;
   localparam int IDX_W        = 2;
   localparam int MAX_HOLD_DEF = 8;
   localparam int CNT_W_DEF    = 8;

   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;

   typedef enum logic {
      ST_IDLE  = IDLE,
      ST_GRANT = GRANT
   } state_e;

   function automatic logic [NUM_REQ-1:0] onehot(
      input logic [IDX_W-1:0] i
   );
      return NUM_REQ'(1) << i;
   endfunction

endpackage

// File: rtl/hi_priority_arbiter_enc.sv
// Highest-index encoder: index of the top set bit plus an all-zero flag.
// Purely combinational; used on the masked request vector.
module hi_index_enc
   import hi_priority_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] in_vec,
   output logic [IDX_W-1:0]   idx,
   output logic               zero
);

   always_comb begin
      idx  = '0;
      zero = 1'b0;
      priority case (1'b1)
         in_vec[3]: idx = 2'd3;
         in_vec[2]: idx = 2'd2;
         in_vec[1]: idx = 2'd1;
         in_vec[0]: idx = 2'd0;
         default:   zero = 1'b1;
      endcase
   end

endmodule

// File: rtl/hi_priority_arbiter.sv
// Sequential arbiter granting a shared resource to the highest-index requester,
// with a hold-time limit and one-arbitration masking of a pre-empted winner.
module hi_priority_arbiter
   import hi_priority_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_REQ-1:0] REQ,
   output logic [NUM_REQ-1:0] GNT,
   output logic [IDX_W-1:0]   IDX,
   output logic               VALID,
   output logic               PREEMPT
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0]   mask_q, mask_d;
   logic                 preempt_q, preempt_d;

   logic [NUM_REQ-1:0]   masked;
   logic [IDX_W-1:0]     enc_idx;
   logic                 enc_z;

   assign masked = REQ & ~mask_q;

   hi_index_enc u_enc (
      .in_vec (masked),
      .idx    (enc_idx),
      .zero   (enc_z)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      idx_d      = idx_q;
      hold_cnt_d = hold_cnt_q;
      mask_d     = mask_q;
      preempt_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // An empty masked vector also retires a stale mask.
            mask_d = '0;
            if (!enc_z) begin
               state_d    = ST_GRANT;
               gnt_d      = onehot(enc_idx);
               idx_d      = enc_idx;
               hold_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (!REQ[idx_q]) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               mask_d    = onehot(idx_q);
               preempt_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         idx_q      <= '0;
         hold_cnt_q <= '0;
         mask_q     <= '0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         idx_q      <= idx_d;
         hold_cnt_q <= hold_cnt_d;
         mask_q     <= mask_d;
         preempt_q  <= preempt_d;
      end
   end

   assign GNT     = gnt_q;
   assign IDX     = idx_q;
   assign VALID   = |gnt_q;
   assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_hi_priority_arbiter.sv
// Randomized and directed bench for hi_priority_arbiter against a
// behavioural model of owner, grant age and pre-empted requester.
module tb_hi_priority_arbiter;

   localparam int MH = 8;

   logic       CLK;
   logic       RST_N;
   logic [3:0] REQ;
   logic [3:0] GNT;
   logic [1:0] IDX;
   logic       VALID;
   logic       PREEMPT;

   int n_vec = 0;
   int n_err = 0;

   // model: owner index (-1 none), cycles already granted, blocked index
   int m_own;
   int m_age;
   int m_block;
   bit m_pre;

   hi_priority_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .REQ     (REQ),
      .GNT     (GNT),
      .IDX     (IDX),
      .VALID   (VALID),
      .PREEMPT (PREEMPT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic int top_bit(input logic [3:0] v);
      for (int i = 3; i >= 0; i--)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic m_reset();
      m_own   = -1;
      m_age   = 0;
      m_block = -1;
      m_pre   = 1'b0;
   endtask

   task automatic m_step(input logic [3:0] r);
      logic [3:0] elig;
      int w;
      m_pre = 1'b0;
      if (m_own < 0) begin
         elig = r;
         if (m_block >= 0) elig[m_block] = 1'b0;
         w = top_bit(elig);
         m_block = -1;
         if (w >= 0) begin
            m_own = w;
            m_age = 1;
         end
      end else if (!r[m_own]) begin
         m_own = -1;
      end else if (m_age == MH) begin
         m_block = m_own;
         m_own   = -1;
         m_pre   = 1'b1;
      end else begin
         m_age++;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [7:0] eg;
      eg = (m_own < 0) ? 8'h0 : 8'(1 << m_own);
      check({tag, ".gnt"}, {4'h0, GNT}, eg);
      check({tag, ".valid"}, {7'h0, VALID}, {7'h0, m_own >= 0});
      check({tag, ".preempt"}, {7'h0, PREEMPT}, {7'h0, m_pre});
      if (m_own >= 0)
         check({tag, ".idx"}, {6'h0, IDX}, 8'(m_own));
   endtask

   task automatic cycle(input logic [3:0] r, input string tag);
      REQ = r;
      @(posedge CLK);
      m_step(r);
      #1;
      compare_all(tag);
   endtask

   logic [3:0] rr;

   initial begin
      m_reset();
      RST_N = 1'b0;
      REQ   = 4'h0;
      #12;
      check("rst.gnt", {4'h0, GNT}, 8'h0);
      check("rst.idx", {6'h0, IDX}, 8'h0);
      check("rst.valid", {7'h0, VALID}, 8'h0);
      check("rst.preempt", {7'h0, PREEMPT}, 8'h0);
      RST_N = 1'b1;

      repeat (10) cycle(4'b0000, "idle");

      repeat (5) cycle(4'b0101, "prio");
      repeat (4) cycle(4'b0001, "handover");
      repeat (2) cycle(4'b0000, "drain");

      repeat (14) cycle(4'b1001, "preempt");
      repeat (4) cycle(4'b1000, "regrant");
      repeat (2) cycle(4'b0000, "drain");

      repeat (14) cycle(4'b1000, "lone");
      repeat (2) cycle(4'b0000, "drain");

      for (int v = 0; v < 16; v++) begin
         cycle(4'(v), "sweep");
         if (v != 0)
            check("sweep.top", {6'h0, IDX}, 8'(top_bit(4'(v))));
         cycle(4'b0000, "sweep");
         cycle(4'b0000, "sweep");
      end

      // asynchronous reset in the middle of a grant
      repeat (3) cycle(4'b1111, "async");
      #2;
      RST_N = 1'b0;
      #1;
      m_reset();
      check("arst.gnt", {4'h0, GNT}, 8'h0);
      check("arst.valid", {7'h0, VALID}, 8'h0);
      check("arst.preempt", {7'h0, PREEMPT}, 8'h0);
      @(posedge CLK);
      #1;
      check("arst.hold", {4'h0, GNT}, 8'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      cycle(4'b1111, "arst.rel");
      check("arst.first", {4'h0, GNT}, 8'h08);

      rr = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)
            rr = 4'($urandom_range(0, 15));
         cycle(rr, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
